// File: rtl/frame_mean_sequencer_if.sv
// Pixel-in / divider / mean-out signal bundle for frame_mean_sequencer.
// The slave modport is the sequencer's view; master is the view of whatever drives it.
interface frame_mean_sequencer_if #(
    parameter int PIX_WIDTH = 14,
    parameter int SUM_WIDTH = 34
);
    logic                 frame_start;
    logic                 frame_end;
    logic                 pix_vld;
    logic [PIX_WIDTH-1:0] pix_data;
    logic                 div_din_en;
    logic [SUM_WIDTH-1:0] div_numer;
    logic [SUM_WIDTH-1:0] div_denom;
    logic                 div_quotient_en;
    logic [SUM_WIDTH-1:0] div_quotient;
    logic                 mean_vld;
    logic [PIX_WIDTH-1:0] mean;
    logic                 busy;
    logic                 overrun;
    logic                 err_timeout;
    logic                 sat_flag;

    modport slave (
        input  frame_start, frame_end, pix_vld, pix_data, div_quotient_en, div_quotient,
        output div_din_en, div_numer, div_denom, mean_vld, mean, busy, overrun,
               err_timeout, sat_flag
    );

    modport master (
        output frame_start, frame_end, pix_vld, pix_data, div_quotient_en, div_quotient,
        input  div_din_en, div_numer, div_denom, mean_vld, mean, busy, overrun,
               err_timeout, sat_flag
    );
endinterface

// File: rtl/frame_mean_sequencer.sv
// Per-frame pixel sum/count accumulator feeding an unsigned divider; the quotient becomes the frame mean.
// Accumulation of the next frame overlaps the divide of the previous one.
module frame_mean_sequencer #(
    parameter int PIX_WIDTH   = 14,
    parameter int CNT_WIDTH   = 20,
    parameter int SUM_WIDTH   = 34,
    parameter int DIV_TIMEOUT = 128
) (
    input  logic                   clk,
    input  logic                   rst,
    frame_mean_sequencer_if.slave  bus
);
    localparam int TMO_W = $clog2(DIV_TIMEOUT);
    localparam logic [TMO_W-1:0]     TMO_LAST = TMO_W'(DIV_TIMEOUT - 1);
    localparam logic [TMO_W-1:0]     TMO_ONE  = {{(TMO_W-1){1'b0}}, 1'b1};
    localparam logic [SUM_WIDTH-1:0] SUM_MAX  = {SUM_WIDTH{1'b1}};
    localparam logic [CNT_WIDTH-1:0] CNT_MAX  = {CNT_WIDTH{1'b1}};
    localparam logic [CNT_WIDTH-1:0] CNT_ONE  = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [SUM_WIDTH-1:0] MEAN_MAX = {{(SUM_WIDTH-PIX_WIDTH){1'b0}}, {PIX_WIDTH{1'b1}}};

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ISSUE = 3'd1,
        ST_WAIT  = 3'd2,
        ST_ZERO  = 3'd3,
        ST_OUT   = 3'd4
    } state_t;

    // Saturating adders return {overflow, value}.
    function automatic logic [SUM_WIDTH:0] sum_sat_add(input logic [SUM_WIDTH-1:0] a,
                                                       input logic [PIX_WIDTH-1:0] p);
        logic [SUM_WIDTH:0] t;
        t = {1'b0, a} + {{(SUM_WIDTH+1-PIX_WIDTH){1'b0}}, p};
        if (t[SUM_WIDTH]) return {1'b1, SUM_MAX};
        else              return t;
    endfunction

    function automatic logic [CNT_WIDTH:0] cnt_sat_inc(input logic [CNT_WIDTH-1:0] a);
        if (a == CNT_MAX) return {1'b1, CNT_MAX};
        else              return {1'b0, a + CNT_ONE};
    endfunction

    function automatic logic [PIX_WIDTH-1:0] clip_mean(input logic [SUM_WIDTH-1:0] q);
        if (q > MEAN_MAX) return {PIX_WIDTH{1'b1}};
        else              return q[PIX_WIDTH-1:0];
    endfunction

    state_t                 state_r, state_nx_s;
    logic                   in_frame_r, sat_r, sat_h_r;
    logic [SUM_WIDTH-1:0]   sum_r, sum_h_r, quot_r;
    logic [CNT_WIDTH-1:0]   cnt_r, cnt_h_r;
    logic [TMO_W-1:0]       tmo_r;
    logic [SUM_WIDTH:0]     sum_ext_s;
    logic [CNT_WIDTH:0]     cnt_ext_s;
    logic [SUM_WIDTH-1:0]   acc_sum_s, snap_sum_s;
    logic [CNT_WIDTH-1:0]   acc_cnt_s, snap_cnt_s;
    logic                   acc_sat_s, snap_sat_s, snap_s;
    logic                   din_en_s, mean_vld_s, sat_flag_s, err_s, overrun_s, busy_s;
    logic [PIX_WIDTH-1:0]   mean_s;
    logic                   din_en_r, mean_vld_r, sat_flag_r, err_r, overrun_r, busy_r;
    logic [PIX_WIDTH-1:0]   mean_r;

    assign sum_ext_s = sum_sat_add(sum_r, bus.pix_data);
    assign cnt_ext_s = cnt_sat_inc(cnt_r);
    assign snap_s    = bus.frame_end & in_frame_r;

    // Running totals including this cycle's pixel
    always_comb begin
        if (bus.pix_vld) begin
            acc_sum_s = sum_ext_s[SUM_WIDTH-1:0];
            acc_cnt_s = cnt_ext_s[CNT_WIDTH-1:0];
            acc_sat_s = sat_r | sum_ext_s[SUM_WIDTH] | cnt_ext_s[CNT_WIDTH];
        end else begin
            acc_sum_s = sum_r;
            acc_cnt_s = cnt_r;
            acc_sat_s = sat_r;
        end
    end

    // Snapshot contents: on a combined end+start the pixel belongs to the new frame
    always_comb begin
        if (bus.frame_start) begin
            snap_sum_s = sum_r;
            snap_cnt_s = cnt_r;
            snap_sat_s = sat_r;
        end else begin
            snap_sum_s = acc_sum_s;
            snap_cnt_s = acc_cnt_s;
            snap_sat_s = acc_sat_s;
        end
    end

    // Frame accumulator
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            in_frame_r <= 1'b0;
            sum_r      <= {SUM_WIDTH{1'b0}};
            cnt_r      <= {CNT_WIDTH{1'b0}};
            sat_r      <= 1'b0;
        end else if (bus.frame_start) begin
            in_frame_r <= 1'b1;
            sum_r      <= bus.pix_vld ? {{(SUM_WIDTH-PIX_WIDTH){1'b0}}, bus.pix_data} : {SUM_WIDTH{1'b0}};
            cnt_r      <= bus.pix_vld ? CNT_ONE : {CNT_WIDTH{1'b0}};
            sat_r      <= 1'b0;
        end else if (snap_s) begin
            in_frame_r <= 1'b0;
            sum_r      <= {SUM_WIDTH{1'b0}};
            cnt_r      <= {CNT_WIDTH{1'b0}};
            sat_r      <= 1'b0;
        end else if (in_frame_r) begin
            sum_r      <= acc_sum_s;
            cnt_r      <= acc_cnt_s;
            sat_r      <= acc_sat_s;
        end
    end

    // FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_r <= ST_IDLE;
        else     state_r <= state_nx_s;
    end

    // FSM next-state logic
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (snap_s) state_nx_s = (snap_cnt_s == {CNT_WIDTH{1'b0}}) ? ST_ZERO : ST_ISSUE;
                else        state_nx_s = ST_IDLE;
            end
            ST_ISSUE: state_nx_s = ST_WAIT;
            ST_WAIT: begin
                if (bus.div_quotient_en)  state_nx_s = ST_OUT;
                else if (tmo_r == TMO_LAST) state_nx_s = ST_IDLE;
                else                      state_nx_s = ST_WAIT;
            end
            ST_ZERO: state_nx_s = ST_IDLE;
            ST_OUT:  state_nx_s = ST_IDLE;
            default: state_nx_s = ST_IDLE;
        endcase
    end

    // Snapshot hold, timeout counter and quotient capture
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sum_h_r <= {SUM_WIDTH{1'b0}};
            cnt_h_r <= {CNT_WIDTH{1'b0}};
            sat_h_r <= 1'b0;
            tmo_r   <= {TMO_W{1'b0}};
            quot_r  <= {SUM_WIDTH{1'b0}};
        end else begin
            if (state_r == ST_IDLE && snap_s) begin
                sum_h_r <= snap_sum_s;
                cnt_h_r <= snap_cnt_s;
                sat_h_r <= snap_sat_s;
            end
            if (state_r == ST_ISSUE)     tmo_r <= {TMO_W{1'b0}};
            else if (state_r == ST_WAIT) tmo_r <= tmo_r + TMO_ONE;
            if (state_r == ST_WAIT && bus.div_quotient_en) quot_r <= bus.div_quotient;
        end
    end

    // FSM output decode (registered below)
    always_comb begin
        din_en_s   = 1'b0;
        mean_vld_s = 1'b0;
        mean_s     = mean_r;
        sat_flag_s = sat_flag_r;
        err_s      = 1'b0;
        case (state_r)
            ST_ISSUE: din_en_s = 1'b1;
            ST_WAIT: begin
                if (!bus.div_quotient_en && tmo_r == TMO_LAST) err_s = 1'b1;
                else                                          err_s = 1'b0;
            end
            ST_ZERO: begin
                mean_s     = {PIX_WIDTH{1'b0}};
                mean_vld_s = 1'b1;
                sat_flag_s = sat_h_r;
            end
            ST_OUT: begin
                mean_s     = clip_mean(quot_r);
                mean_vld_s = 1'b1;
                sat_flag_s = sat_h_r;
            end
            default: din_en_s = 1'b0;
        endcase
        overrun_s = snap_s & (state_r != ST_IDLE);
        busy_s    = (state_nx_s == ST_ISSUE) | (state_nx_s == ST_WAIT);
    end

    // Output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            din_en_r   <= 1'b0;
            mean_vld_r <= 1'b0;
            mean_r     <= {PIX_WIDTH{1'b0}};
            sat_flag_r <= 1'b0;
            err_r      <= 1'b0;
            overrun_r  <= 1'b0;
            busy_r     <= 1'b0;
        end else begin
            din_en_r   <= din_en_s;
            mean_vld_r <= mean_vld_s;
            mean_r     <= mean_s;
            sat_flag_r <= sat_flag_s;
            err_r      <= err_s;
            overrun_r  <= overrun_s;
            busy_r     <= busy_s;
        end
    end

    assign bus.div_din_en  = din_en_r;
    assign bus.div_numer   = sum_h_r;
    assign bus.div_denom   = {{(SUM_WIDTH-CNT_WIDTH){1'b0}}, cnt_h_r};
    assign bus.mean_vld    = mean_vld_r;
    assign bus.mean        = mean_r;
    assign bus.busy        = busy_r;
    assign bus.overrun     = overrun_r;
    assign bus.err_timeout = err_r;
    assign bus.sat_flag    = sat_flag_r;
endmodule

// File: tb/tb_frame_mean_sequencer.sv
// Directed bench: two sequencers (CNT_WIDTH 20 and 4) share one stimulus stream and a scripted divider.
module tb_frame_mean_sequencer;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    frame_mean_sequencer_if #(.PIX_WIDTH(14), .SUM_WIDTH(34)) ifa ();
    frame_mean_sequencer_if #(.PIX_WIDTH(14), .SUM_WIDTH(34)) ifb ();

    assign ifb.frame_start     = ifa.frame_start;
    assign ifb.frame_end       = ifa.frame_end;
    assign ifb.pix_vld         = ifa.pix_vld;
    assign ifb.pix_data        = ifa.pix_data;
    assign ifb.div_quotient_en = ifa.div_quotient_en;
    assign ifb.div_quotient    = ifa.div_quotient;

    frame_mean_sequencer #(.PIX_WIDTH(14), .CNT_WIDTH(20), .SUM_WIDTH(34), .DIV_TIMEOUT(128))
        dut_a (.clk(clk), .rst(rst), .bus(ifa));
    frame_mean_sequencer #(.PIX_WIDTH(14), .CNT_WIDTH(4), .SUM_WIDTH(34), .DIV_TIMEOUT(128))
        dut_b (.clk(clk), .rst(rst), .bus(ifb));

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic s, input logic e, input logic v, input logic [13:0] p);
        ifa.frame_start = s;
        ifa.frame_end   = e;
        ifa.pix_vld     = v;
        ifa.pix_data    = p;
        step();
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Called at the din_en cycle; returns two cycles after the quotient strobe.
    task automatic divide(input int n, input logic [33:0] q);
        repeat (n) step();
        ifa.div_quotient_en = 1'b1;
        ifa.div_quotient    = q;
        step();
        ifa.div_quotient_en = 1'b0;
        step();
    endtask

    initial begin
        ifa.frame_start = 1'b0; ifa.frame_end = 1'b0; ifa.pix_vld = 1'b0; ifa.pix_data = 14'd0;
        ifa.div_quotient_en = 1'b0; ifa.div_quotient = 34'd0;
        step(); step();
        chk("rst_mean_vld", {63'd0, ifa.mean_vld}, 64'd0);
        chk("rst_mean", {50'd0, ifa.mean}, 64'd0);
        chk("rst_busy", {63'd0, ifa.busy}, 64'd0);
        chk("rst_din_en", {63'd0, ifa.div_din_en}, 64'd0);
        chk("rst_numer", {30'd0, ifa.div_numer}, 64'd0);
        rst = 1'b0;
        step();

        // T1: 10,20,30,40 -> 100/4 = 25
        drive(1'b1, 1'b0, 1'b1, 14'd10);
        drive(1'b0, 1'b0, 1'b1, 14'd20);
        drive(1'b0, 1'b0, 1'b1, 14'd30);
        drive(1'b0, 1'b1, 1'b1, 14'd40);
        chk("t1_busy_t1", {63'd0, ifa.busy}, 64'd1);
        chk("t1_din_en_t1", {63'd0, ifa.div_din_en}, 64'd0);
        drive(1'b0, 1'b0, 1'b0, 14'd0);
        chk("t1_din_en_t2", {63'd0, ifa.div_din_en}, 64'd1);
        chk("t1_numer", {30'd0, ifa.div_numer}, 64'd100);
        chk("t1_denom", {30'd0, ifa.div_denom}, 64'd4);
        step();
        chk("t1_din_en_pulse", {63'd0, ifa.div_din_en}, 64'd0);
        repeat (19) step();
        ifa.div_quotient_en = 1'b1; ifa.div_quotient = 34'd25;
        step();
        ifa.div_quotient_en = 1'b0;
        chk("t1_mean_vld_d1", {63'd0, ifa.mean_vld}, 64'd0);
        step();
        chk("t1_mean_vld_d2", {63'd0, ifa.mean_vld}, 64'd1);
        chk("t1_mean", {50'd0, ifa.mean}, 64'd25);
        chk("t1_sat", {63'd0, ifa.sat_flag}, 64'd0);
        chk("t1_busy_done", {63'd0, ifa.busy}, 64'd0);
        step();
        chk("t1_mean_vld_pulse", {63'd0, ifa.mean_vld}, 64'd0);
        chk("t1_mean_hold", {50'd0, ifa.mean}, 64'd25);

        // T2: empty frame -> mean 0 at T+2, no divide
        drive(1'b1, 1'b0, 1'b0, 14'd0);
        drive(1'b0, 1'b1, 1'b0, 14'd0);
        chk("t2_din_en_t1", {63'd0, ifa.div_din_en}, 64'd0);
        chk("t2_mean_vld_t1", {63'd0, ifa.mean_vld}, 64'd0);
        drive(1'b0, 1'b0, 1'b0, 14'd0);
        chk("t2_din_en_t2", {63'd0, ifa.div_din_en}, 64'd0);
        chk("t2_mean_vld_t2", {63'd0, ifa.mean_vld}, 64'd1);
        chk("t2_mean", {50'd0, ifa.mean}, 64'd0);
        step(); step();

        // T3: 6,10 -> 16/2 = 8; a second frame ends 5 cycles into the divide
        drive(1'b1, 1'b0, 1'b1, 14'd6);
        drive(1'b0, 1'b1, 1'b1, 14'd10);
        drive(1'b0, 1'b0, 1'b0, 14'd0);
        chk("t3_din_en", {63'd0, ifa.div_din_en}, 64'd1);
        chk("t3_numer", {30'd0, ifa.div_numer}, 64'd16);
        drive(1'b1, 1'b0, 1'b1, 14'd100);
        drive(1'b0, 1'b0, 1'b0, 14'd0);
        step(); step(); step();
        drive(1'b0, 1'b1, 1'b0, 14'd0);
        chk("t3_overrun", {63'd0, ifa.overrun}, 64'd1);
        chk("t3_numer_kept", {30'd0, ifa.div_numer}, 64'd16);
        chk("t3_denom_kept", {30'd0, ifa.div_denom}, 64'd2);
        drive(1'b0, 1'b0, 1'b0, 14'd0);
        chk("t3_overrun_pulse", {63'd0, ifa.overrun}, 64'd0);
        repeat (13) step();
        ifa.div_quotient_en = 1'b1; ifa.div_quotient = 34'd8;
        step();
        ifa.div_quotient_en = 1'b0;
        step();
        chk("t3_mean_vld", {63'd0, ifa.mean_vld}, 64'd1);
        chk("t3_mean", {50'd0, ifa.mean}, 64'd8);
        step();
        chk("t3_no_second_mean", {63'd0, ifa.mean_vld}, 64'd0);
        step();
        // third frame: 1..5 -> 15/5 = 3
        drive(1'b1, 1'b0, 1'b1, 14'd1);
        drive(1'b0, 1'b0, 1'b1, 14'd2);
        drive(1'b0, 1'b0, 1'b1, 14'd3);
        drive(1'b0, 1'b0, 1'b1, 14'd4);
        drive(1'b0, 1'b1, 1'b1, 14'd5);
        drive(1'b0, 1'b0, 1'b0, 14'd0);
        chk("t3c_din_en", {63'd0, ifa.div_din_en}, 64'd1);
        chk("t3c_numer", {30'd0, ifa.div_numer}, 64'd15);
        chk("t3c_denom", {30'd0, ifa.div_denom}, 64'd5);
        divide(3, 34'd3);
        chk("t3c_mean_vld", {63'd0, ifa.mean_vld}, 64'd1);
        chk("t3c_mean", {50'd0, ifa.mean}, 64'd3);
        step();

        // T4: divider silent -> err_timeout 128 cycles after din_en
        drive(1'b1, 1'b0, 1'b1, 14'd50);
        drive(1'b0, 1'b1, 1'b1, 14'd70);
        drive(1'b0, 1'b0, 1'b0, 14'd0);
        chk("t4_din_en", {63'd0, ifa.div_din_en}, 64'd1);
        repeat (127) step();
        chk("t4_err_early", {63'd0, ifa.err_timeout}, 64'd0);
        chk("t4_busy_c127", {63'd0, ifa.busy}, 64'd1);
        step();
        chk("t4_err", {63'd0, ifa.err_timeout}, 64'd1);
        chk("t4_busy_idle", {63'd0, ifa.busy}, 64'd0);
        chk("t4_mean_kept", {50'd0, ifa.mean}, 64'd3);
        ifa.div_quotient_en = 1'b1; ifa.div_quotient = 34'd77;
        step();
        ifa.div_quotient_en = 1'b0;
        chk("t4_err_pulse", {63'd0, ifa.err_timeout}, 64'd0);
        step();
        chk("t4_stray_q_vld", {63'd0, ifa.mean_vld}, 64'd0);
        chk("t4_stray_q_mean", {50'd0, ifa.mean}, 64'd3);
        // recovery frame: 9,9,9 -> 27/3 = 9
        drive(1'b1, 1'b0, 1'b1, 14'd9);
        drive(1'b0, 1'b0, 1'b1, 14'd9);
        drive(1'b0, 1'b1, 1'b1, 14'd9);
        drive(1'b0, 1'b0, 1'b0, 14'd0);
        chk("t4r_din_en", {63'd0, ifa.div_din_en}, 64'd1);
        chk("t4r_numer", {30'd0, ifa.div_numer}, 64'd27);
        divide(4, 34'd9);
        chk("t4r_mean_vld", {63'd0, ifa.mean_vld}, 64'd1);
        chk("t4r_mean", {50'd0, ifa.mean}, 64'd9);
        step();

        // T5: 20 pixels of 0x3FFF; CNT_WIDTH=4 instance saturates its count at 15
        drive(1'b1, 1'b0, 1'b1, 14'h3FFF);
        for (int i = 0; i < 18; i++) drive(1'b0, 1'b0, 1'b1, 14'h3FFF);
        drive(1'b0, 1'b1, 1'b1, 14'h3FFF);
        drive(1'b0, 1'b0, 1'b0, 14'd0);
        chk("t5_a_numer", {30'd0, ifa.div_numer}, 64'd327660);
        chk("t5_a_denom", {30'd0, ifa.div_denom}, 64'd20);
        chk("t5_b_din_en", {63'd0, ifb.div_din_en}, 64'd1);
        chk("t5_b_numer", {30'd0, ifb.div_numer}, 64'd327660);
        chk("t5_b_denom", {30'd0, ifb.div_denom}, 64'd15);
        divide(3, 34'd21844);
        chk("t5_b_mean_vld", {63'd0, ifb.mean_vld}, 64'd1);
        chk("t5_b_mean", {50'd0, ifb.mean}, 64'h3FFF);
        chk("t5_b_sat", {63'd0, ifb.sat_flag}, 64'd1);
        chk("t5_a_sat", {63'd0, ifa.sat_flag}, 64'd0);
        step();

        // T6: reset during WAIT
        drive(1'b1, 1'b0, 1'b1, 14'd4);
        drive(1'b0, 1'b1, 1'b1, 14'd4);
        drive(1'b0, 1'b0, 1'b0, 14'd0);
        chk("t6_din_en", {63'd0, ifa.div_din_en}, 64'd1);
        step(); step(); step();
        chk("t6_busy_wait", {63'd0, ifa.busy}, 64'd1);
        rst = 1'b1;
        step();
        chk("t6_busy", {63'd0, ifa.busy}, 64'd0);
        chk("t6_numer", {30'd0, ifa.div_numer}, 64'd0);
        chk("t6_denom", {30'd0, ifa.div_denom}, 64'd0);
        chk("t6_mean", {50'd0, ifa.mean}, 64'd0);
        chk("t6_sat", {63'd0, ifb.sat_flag}, 64'd0);
        rst = 1'b0;
        ifa.div_quotient_en = 1'b1; ifa.div_quotient = 34'd55;
        step();
        ifa.div_quotient_en = 1'b0;
        step();
        chk("t6_late_q_vld", {63'd0, ifa.mean_vld}, 64'd0);
        step();
        chk("t6_late_q_mean", {50'd0, ifa.mean}, 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
